mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port load/store arbiter onto data_memory; define MEM_ARB_RR_EN for round-robin, else p0 has fixed priority
module mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [2:0]        p0_size,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [2:0]        p1_size,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic              w_sel, w_gnt, w_we, w_illegal, w_resp, w_unused;
  logic [ADDR_W+1:0] w_addr;
  logic [31:0]       w_wdata, w_lane, w_ld, w_rep;
  logic [2:0]        w_size;
  logic [3:0]        w_strb;
  logic              r_owner, r_we, r_err;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic [2:0]        r_size;
  assign w_unused = &{1'b0, p0_addr[31:ADDR_W+2], p1_addr[31:ADDR_W+2]};
`ifdef MEM_ARB_RR_EN
  logic r_ptr;
  assign w_sel = p1_req & (~p0_req | r_ptr);
  always_ff @(posedge clk)
    if (rst) r_ptr <= 1'b0;
    else if (w_gnt) r_ptr <= ~w_sel;
`else
  assign w_sel = p1_req & ~p0_req;
`endif
  assign w_gnt   = (r_state == IDLE) & (p0_req | p1_req) & ~rst;
  assign w_we    = w_sel ? p1_we : p0_we;
  assign w_addr  = w_sel ? p1_addr[ADDR_W+1:0] : p0_addr[ADDR_W+1:0];
  assign w_wdata = w_sel ? p1_wdata : p0_wdata;
  assign w_size  = w_sel ? p1_size : p0_size;
  assign w_illegal = (w_size == 3'b011) | (w_size[2:1] == 2'b11) | (w_we & w_size[2]) |
                     ((w_size[1:0] == 2'b01) & w_addr[0]) | ((w_size[1:0] == 2'b10) & |w_addr[1:0]);
  assign w_strb = r_size[1] ? 4'b1111 : (r_size[0] ? 4'b0011 : 4'b0001) << r_addr[1:0];
  assign w_rep  = r_size[1] ? r_wdata : r_size[0] ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
  assign w_lane = mem_rdata >> {r_addr[1:0], 3'b000};
  assign w_ld   = r_size[1] ? mem_rdata :
                  r_size[0] ? {{16{~r_size[2] & w_lane[15]}}, w_lane[15:0]} :
                              {{24{~r_size[2] & w_lane[7]}}, w_lane[7:0]};
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE:      w_next = w_gnt ? (w_illegal ? RESP : ACCESS) : IDLE;
      ACCESS:    w_next = r_we ? RESP : READ_WAIT;
      READ_WAIT: w_next = RESP;
      default:   w_next = IDLE;
    endcase
  end
  // A store on the mem_* lines is left ungated by rst so it completes; responses are suppressed by rst.
  always_comb begin
    w_resp    = (r_state == RESP) & ~rst;
    p0_gnt    = w_gnt & ~w_sel;
    p1_gnt    = w_gnt & w_sel;
    p0_rvalid = w_resp & ~r_owner;
    p1_rvalid = w_resp & r_owner;
    p0_rdata  = p0_rvalid ? r_rdata : 32'd0;
    p1_rdata  = p1_rvalid ? r_rdata : 32'd0;
    p0_err    = p0_rvalid & r_err;
    p1_err    = p1_rvalid & r_err;
    mem_we    = (r_state == ACCESS) & r_we;
    mem_addr  = (r_state == ACCESS) ? r_addr[ADDR_W+1:2] : '0;
    mem_wstrb = mem_we ? w_strb : 4'd0;
    mem_wdata = mem_we ? w_rep : 32'd0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_gnt) begin
        r_owner <= w_sel;
        r_we    <= w_we;
        r_err   <= w_illegal;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_size  <= w_size;
        r_rdata <= '0;
      end
      if (r_state == READ_WAIT) r_rdata <= w_ld;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a synchronous data_memory model
module tb_mem_arbiter;
  logic        clk = 1'b0, rst;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [2:0]  p0_size;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [2:0]  p1_size;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  int          n_chk = 0, n_fail = 0;
  int          lat;
  logic        gnt_ok, saw_we, saw_strb, other_rv, er, seen;
  logic [31:0] rd, wstrb_s, wdata_s, addr_s;

  mem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] sz);
    @(posedge clk); #1;
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_size = sz; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_size = sz; end
    gnt_ok = 0; saw_we = 0; saw_strb = 0; other_rv = 0; lat = -1;
    rd = 'x; er = 1'bx; wstrb_s = 0; wdata_s = 0; addr_s = 0;
    for (int i = 0; i < 10 && !gnt_ok; i++) begin
      @(negedge clk);
      gnt_ok = port ? p1_gnt : p0_gnt;
    end
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;
    for (int n = 1; n <= 6 && lat < 0; n++) begin
      @(negedge clk);
      if (mem_we) saw_we = 1;
      if (mem_wstrb != 0) begin saw_strb = 1; wstrb_s = mem_wstrb; wdata_s = mem_wdata; addr_s = mem_addr; end
      if (port ? p0_rvalid : p1_rvalid) other_rv = 1;
      if (port ? p1_rvalid : p0_rvalid) begin
        lat = n;
        rd = port ? p1_rdata : p0_rdata;
        er = port ? p1_err : p0_err;
      end
    end
  endtask

  task automatic check_txn(input string tag, input int elat, input logic eerr, input logic [31:0] erd);
    chk({tag, "_gnt"}, gnt_ok, 1);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_err"}, er, eerr);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_other_rvalid"}, other_rv, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    rst = 1;
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_wdata = 0; p0_size = 3'b010;
    p1_req = 1; p1_we = 0; p1_addr = 32'h10; p1_wdata = 0; p1_size = 3'b010;
    repeat (2) @(negedge clk);
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    @(posedge clk); #1;
    rst = 0; p0_req = 0; p1_req = 0;
    repeat (2) @(negedge clk);
    chk("idle_no_gnt", {p0_gnt, p1_gnt}, 0);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 3'b010);
    check_txn("sw_p0", 2, 0, 0);
    chk("sw_mem_we", saw_we, 1);
    chk("sw_addr", addr_s, 32'h04);
    chk("sw_wstrb", wstrb_s, 4'b1111);
    chk("sw_wdata", wdata_s, 32'hDEADBEEF);

    txn(0, 0, 32'h10, 0, 3'b010);
    check_txn("lw_p0", 3, 0, 32'hDEADBEEF);
    chk("lw_no_we", saw_we, 0);

    txn(1, 1, 32'h13, 32'h000000A5, 3'b000);
    check_txn("sb_p1", 2, 0, 0);
    chk("sb_addr", addr_s, 32'h04);
    chk("sb_wstrb", wstrb_s, 4'b1000);
    chk("sb_wdata", wdata_s, 32'hA5A5A5A5);

    txn(1, 0, 32'h13, 0, 3'b000);
    check_txn("lb_p1", 3, 0, 32'hFFFFFFA5);
    txn(1, 0, 32'h13, 0, 3'b100);
    check_txn("lbu_p1", 3, 0, 32'h000000A5);
    txn(1, 0, 32'h12, 0, 3'b001);
    check_txn("lh_p1", 3, 0, 32'hFFFFA5AD);
    txn(1, 0, 32'h12, 0, 3'b101);
    check_txn("lhu_p1", 3, 0, 32'h0000A5AD);
    txn(0, 0, 32'h11, 0, 3'b000);
    check_txn("lb_lane1", 3, 0, 32'hFFFFFFBE);

    txn(0, 1, 32'h22, 32'h00001234, 3'b001);
    check_txn("sh_p0", 2, 0, 0);
    chk("sh_addr", addr_s, 32'h08);
    chk("sh_wstrb", wstrb_s, 4'b1100);
    chk("sh_wdata", wdata_s, 32'h12341234);
    txn(0, 0, 32'h20, 0, 3'b010);
    check_txn("lw_after_sh", 3, 0, 32'h12340000);

    txn(0, 0, 32'h21, 0, 3'b001);
    check_txn("lh_misaligned", 1, 1, 0);
    chk("lh_mis_no_we", saw_we, 0);
    chk("lh_mis_no_strb", saw_strb, 0);
    txn(1, 1, 32'h10, 32'h11111111, 3'b100);
    check_txn("store_unsigned", 1, 1, 0);
    chk("store_unsigned_no_we", saw_we, 0);
    txn(0, 0, 32'h22, 0, 3'b010);
    check_txn("lw_misaligned", 1, 1, 0);
    txn(1, 0, 32'h10, 0, 3'b011);
    check_txn("size_011", 1, 1, 0);
    txn(0, 0, 32'h10, 0, 3'b010);
    check_txn("lw_intact", 3, 0, 32'hA5ADBEEF);

    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_size = 3'b010;
    p1_req = 1; p1_we = 0; p1_addr = 32'h20; p1_size = 3'b010;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (p0_gnt | p1_gnt) begin
          seen = 1;
          chk("arb_onehot", p0_gnt & p1_gnt, 0);
`ifdef MEM_ARB_RR_EN
          chk("arb_rr_p1_gnt", p1_gnt, (k % 2 == 1));
`else
          chk("arb_fixed_p1_gnt", p1_gnt, 0);
`endif
        end
      end
      chk("arb_grant_seen", seen, 1);
    end
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;
    repeat (5) @(posedge clk);

    #1; p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_size = 3'b010;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = p0_gnt;
    end
    chk("abort_gnt", seen, 1);
    @(posedge clk); #1;
    p0_req = 0; rst = 1;
    @(negedge clk);
    chk("abort_rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("abort_rst_mem_we", mem_we, 0);
    @(posedge clk); #1; rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (p0_rvalid | p1_rvalid) seen = 1;
    end
    chk("abort_no_rvalid", seen, 0);
    txn(0, 0, 32'h10, 0, 3'b010);
    check_txn("post_abort_lw", 3, 0, 32'hA5ADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
